// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU execute stage has priority, host/debug port gets a
// req/ack slot with a bounded wait so it can never be starved indefinitely.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    ARB = 1'b0,
    ACK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;

  logic                cpu_req;
  logic                wait_full;
  logic                host_grant;

  assign cpu_req    = cpu_rd_i | cpu_wr_i;
  assign wait_full  = (wait_cnt_q == WAIT_W'(MAX_WAIT));
  // Reset gates the grant so a grant cycle under reset has no memory side effect.
  assign host_grant = reset & (state_q == ARB) & host_req_i & (~cpu_req | wait_full);

  assign cpu_rdata_o  = mem_rdata_i;
  assign host_ack_o   = host_ack_q;
  assign host_rdata_o = host_rdata_q;

  // Memory port mux; CPU drives address/data whenever the host is not granted.
  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    mem_we_o    = cpu_wr_i;
    mem_re_o    = cpu_rd_i & ~cpu_wr_i;
    cpu_stall_o = 1'b0;
    if (host_grant) begin
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
      mem_we_o    = host_we_i;
      mem_re_o    = ~host_we_i;
      cpu_stall_o = cpu_req;
    end
    if (!reset) begin
      mem_we_o = 1'b0;
      mem_re_o = 1'b0;
    end
  end

  // Next-state, starvation counter and host response.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    unique case (state_q)
      ARB: begin
        if (host_grant) begin
          state_d    = ACK;
          wait_cnt_d = '0;
          host_ack_d = 1'b1;
          if (!host_we_i) begin
            host_rdata_d = mem_rdata_i;
          end
        end else if (host_req_i && cpu_req) begin
          if (!wait_full) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else if (!host_req_i) begin
          wait_cnt_d = '0;
        end
      end
      ACK: begin
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule
